midi_voice_allocator: RTL and testbench
=======================================

Name: midi_voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI front end and the synth voice engines.
- Accepts decoded note-on/note-off events one at a time through a valid/ready handshake.
- Assigns each note-on to one of NUM_VOICES voice slots, releases the matching slot on note-off, and steals the oldest voice when all slots are busy.
- Drives per-voice gate, note, velocity and trigger to the voice datapath.

Parameters:
- NUM_VOICES, 4: number of voice slots, range 2..16.
- AGE_W, 4: width of the per-voice saturating age counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- evt_valid  in  1  event present
- evt_ready  out  1  allocator can accept an event
- evt_note_on  in  1  1 = note-on, 0 = note-off
- evt_note  in  7  MIDI note number
- evt_velocity  in  7  MIDI velocity
- panic  in  1  all-notes-off request, level-sampled
- voice_gate  out  NUM_VOICES  per-voice gate, held high while the note is sounding
- voice_note  out  NUM_VOICES*7  packed note per voice; slot i occupies bits [7i+6:7i]
- voice_velocity  out  NUM_VOICES*7  packed velocity per voice
- voice_trigger  out  NUM_VOICES  one-cycle pulse when a slot is (re)started
- steal_pulse  out  1  one-cycle pulse when an active voice is stolen
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - all voice_gate, voice_note, voice_velocity, voice_trigger = 0
  - steal_pulse = 0, all ages = 0
  - FSM = IDLE, so evt_ready = 1 and busy = 0
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - evt_ready = 1.
  - On evt_valid && evt_ready, latch note_on/note/velocity, set scan index = 0, go to SCAN.
- Velocity-0 rule: a note-on with velocity 0 is latched as a note-off.
- SCAN:
  - One slot examined per cycle, index 0..NUM_VOICES-1; evt_ready = 0.
  - Records three results:
    - first slot with gate = 1 and note equal to the latched note (match)
    - lowest-index slot with gate = 0 (free)
    - slot with the largest age (oldest); ties go to the lowest index
  - After index NUM_VOICES-1, go to COMMIT.
- COMMIT (one cycle, evt_ready = 0); register updates take effect at the end of this cycle:
  - Note-on with match: retrigger that slot. Velocity is updated, voice_trigger pulses, age is cleared.
  - Note-on, no match, free slot found: load note and velocity into the free slot, gate = 1, trigger pulses, age = 0.
  - Note-on, all slots busy: overwrite the oldest slot, trigger pulses, steal_pulse pulses, age = 0.
  - Note-off with match: gate = 0; note and velocity are retained.
  - Note-off with no match: no change.
  - Return to IDLE.
- Aging:
  - On every committed note-on, every other slot with gate = 1 increments its age.
  - Age saturates at 2^AGE_W-1.
  - Slots with gate = 0 hold age 0.
- Latency and throughput:
  - Event accepted at edge 0; outputs change at edge NUM_VOICES+1.
  - evt_ready returns high in the following cycle.
  - Throughput is one event per NUM_VOICES+2 cycles.
- voice_trigger and steal_pulse are high for exactly one cycle after COMMIT, then return to 0.
- panic:
  - Overrides all other activity in any state.
  - Next edge: all gates = 0, all ages = 0, any in-flight event is discarded, FSM goes to IDLE.
  - Note and velocity registers are retained.
  - evt_ready = 0 while panic is high.
- An asynchronous reset mid-SCAN or mid-COMMIT aborts the event with no partial update.
- evt_* inputs are ignored while evt_ready = 0; the source must hold them until the handshake completes.

Decomposition:
- Package midi_pkg holds:
  - state enum alloc_state_t {IDLE, SCAN, COMMIT}
  - NOTE_W = 7, VEL_W = 7
  - MIDI status constants STATUS_NOTE_OFF = 4'h8, STATUS_NOTE_ON = 4'h9
- Sub-module midi_voice_slot, instantiated NUM_VOICES times. It holds one slot's gate, note, velocity, age and trigger registers. Control inputs: load, release, age_inc, clear.
- The allocator itself contains only the FSM, the scan comparators and the commit decode.

Test Plan:
- Reset, then note-on 60/100 → slot 0: gate = 1, note = 60, vel = 100, trigger[0] pulses at cycle NUM_VOICES+1 after accept; steal_pulse = 0.
- Note-ons 60, 62, 64, 65, then note-on 67 with NUM_VOICES = 4 → slot 0 (age 3) is stolen, note = 67, steal_pulse pulses once; slots 1-3 are unchanged.
- Note-on 60/100, then note-on 60/0 → slot 0 gate = 0, note stays 60, no trigger; a following note-off 61 produces no output change.
- Note-on 60/100, then note-on 60/50 → same slot 0 retriggers with vel = 50, trigger pulses, no second slot is used.
- Assert panic mid-SCAN with 3 voices active → all gates = 0 on the next edge, the in-flight event is discarded, evt_ready = 1 the cycle after panic is released.
- Hold evt_valid high continuously with 6 distinct note-ons → exactly one accept per 6 cycles, with evt_ready low during SCAN and COMMIT.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice allocator.
package midi_pkg;

    localparam int unsigned NOTE_W = 7;
    localparam int unsigned VEL_W  = 7;

    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

    typedef struct packed {
        logic              note_on;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  velocity;
    } midi_evt_t;

    // A note-on carrying velocity 0 is a note-off by MIDI convention.
    function automatic logic evt_is_note_on(input logic note_on, input logic [VEL_W-1:0] velocity);
        return note_on && (velocity != '0);
    endfunction

endpackage

// File: rtl/midi_voice_slot.sv
// One voice slot: gate, note, velocity, saturating age and trigger pulse.
module midi_voice_slot
    import midi_pkg::*;
#(
    parameter int unsigned AGE_W = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_release,
    input  logic              i_age_inc,
    input  logic              i_clear,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [VEL_W-1:0]  i_velocity,
    output logic              o_gate,
    output logic [NOTE_W-1:0] o_note,
    output logic [VEL_W-1:0]  o_velocity,
    output logic [AGE_W-1:0]  o_age,
    output logic              o_trigger
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic              r_gate;
    logic [NOTE_W-1:0] r_note;
    logic [VEL_W-1:0]  r_velocity;
    logic [AGE_W-1:0]  r_age;
    logic              r_trigger;

    // clear (panic) wins over everything and keeps note/velocity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate     <= 1'b0;
            r_note     <= '0;
            r_velocity <= '0;
            r_age      <= '0;
            r_trigger  <= 1'b0;
        end else if (i_clear) begin
            r_gate    <= 1'b0;
            r_age     <= '0;
            r_trigger <= 1'b0;
        end else begin
            r_trigger <= i_load;
            if (i_load) begin
                r_gate     <= 1'b1;
                r_note     <= i_note;
                r_velocity <= i_velocity;
                r_age      <= '0;
            end else if (i_release) begin
                r_gate <= 1'b0;
                r_age  <= '0;
            end else if (i_age_inc && r_gate && (r_age != AGE_MAX)) begin
                r_age <= r_age + AGE_W'(1);
            end
        end
    end

    assign o_gate     = r_gate;
    assign o_note     = r_note;
    assign o_velocity = r_velocity;
    assign o_age      = r_age;
    assign o_trigger  = r_trigger;

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: serial slot scan, then a single commit cycle
// that starts, retriggers, steals or releases one voice.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          evt_valid,
    output logic                          evt_ready,
    input  logic                          evt_note_on,
    input  logic [NOTE_W-1:0]             evt_note,
    input  logic [VEL_W-1:0]              evt_velocity,
    input  logic                          panic,
    output logic [NUM_VOICES-1:0]         voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0]  voice_note,
    output logic [NUM_VOICES*VEL_W-1:0]   voice_velocity,
    output logic [NUM_VOICES-1:0]         voice_trigger,
    output logic                          steal_pulse,
    output logic                          busy
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t r_state;
    alloc_state_t w_state_nxt;
    logic         w_accept;
    logic         w_scan_en;
    logic         w_commit;
    logic         w_ready;

    midi_evt_t        r_evt;
    logic [IDX_W-1:0] r_idx;
    logic             r_match_found;
    logic [IDX_W-1:0] r_match_idx;
    logic             r_free_found;
    logic [IDX_W-1:0] r_free_idx;
    logic [IDX_W-1:0] r_old_idx;
    logic [AGE_W-1:0] r_old_age;
    logic             r_steal;

    logic [NUM_VOICES-1:0] w_gate;
    logic [NUM_VOICES-1:0] w_trigger;
    logic [NOTE_W-1:0]     w_note [NUM_VOICES];
    logic [VEL_W-1:0]      w_vel  [NUM_VOICES];
    logic [AGE_W-1:0]      w_age  [NUM_VOICES];

    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_release;
    logic [NUM_VOICES-1:0] w_age_inc;
    logic [IDX_W-1:0]      w_tgt;
    logic                  w_steal;

    logic              w_cur_gate;
    logic [NOTE_W-1:0] w_cur_note;
    logic [AGE_W-1:0]  w_cur_age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_scan_en   = 1'b0;
        w_commit    = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (evt_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                w_scan_en = 1'b1;
                if (r_idx == LAST_IDX) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // panic discards whatever is in flight
        if (panic) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
            w_scan_en   = 1'b0;
            w_commit    = 1'b0;
            w_ready     = 1'b0;
        end
    end

    assign w_cur_gate = w_gate[r_idx];
    assign w_cur_note = w_note[r_idx];
    assign w_cur_age  = w_age[r_idx];

    // Event latch and per-cycle scan bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt         <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
        end else if (w_accept) begin
            r_evt.note_on  <= evt_is_note_on(evt_note_on, evt_velocity);
            r_evt.note     <= evt_note;
            r_evt.velocity <= evt_velocity;
            r_idx          <= '0;
            r_match_found  <= 1'b0;
            r_match_idx    <= '0;
            r_free_found   <= 1'b0;
            r_free_idx     <= '0;
            r_old_idx      <= '0;
            r_old_age      <= '0;
        end else if (w_scan_en) begin
            r_idx <= r_idx + IDX_W'(1);
            if (!r_match_found && w_cur_gate && (w_cur_note == r_evt.note)) begin
                r_match_found <= 1'b1;
                r_match_idx   <= r_idx;
            end
            if (!r_free_found && !w_cur_gate) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
            end
            // strict compare keeps the lowest index on ties
            if ((r_idx == '0) || (w_cur_age > r_old_age)) begin
                r_old_idx <= r_idx;
                r_old_age <= w_cur_age;
            end
        end
    end

    always_comb begin
        w_load    = '0;
        w_release = '0;
        w_age_inc = '0;
        w_tgt     = '0;
        w_steal   = 1'b0;
        if (w_commit) begin
            if (r_evt.note_on) begin
                if (r_match_found) begin
                    w_tgt = r_match_idx;
                end else if (r_free_found) begin
                    w_tgt = r_free_idx;
                end else begin
                    w_tgt   = r_old_idx;
                    w_steal = 1'b1;
                end
                w_load    = NUM_VOICES'(1) << w_tgt;
                w_age_inc = ~w_load & w_gate;
            end else if (r_match_found) begin
                w_release = NUM_VOICES'(1) << r_match_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_steal <= 1'b0;
        else        r_steal <= w_steal;
    end

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
        midi_voice_slot #(
            .AGE_W (AGE_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_load[gi]),
            .i_release  (w_release[gi]),
            .i_age_inc  (w_age_inc[gi]),
            .i_clear    (panic),
            .i_note     (r_evt.note),
            .i_velocity (r_evt.velocity),
            .o_gate     (w_gate[gi]),
            .o_note     (w_note[gi]),
            .o_velocity (w_vel[gi]),
            .o_age      (w_age[gi]),
            .o_trigger  (w_trigger[gi])
        );
        assign voice_note[gi*NOTE_W +: NOTE_W]    = w_note[gi];
        assign voice_velocity[gi*VEL_W +: VEL_W]  = w_vel[gi];
    end

    assign voice_gate    = w_gate;
    assign voice_trigger = w_trigger;
    assign steal_pulse   = r_steal;
    assign evt_ready     = w_ready;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed self-checking bench for midi_voice_allocator (4 voices).
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          evt_valid = 1'b0;
    logic          evt_ready;
    logic          evt_note_on = 1'b0;
    logic [6:0]    evt_note = '0;
    logic [6:0]    evt_velocity = '0;
    logic          panic = 1'b0;
    logic [NV-1:0] voice_gate;
    logic [NV*7-1:0] voice_note;
    logic [NV*7-1:0] voice_velocity;
    logic [NV-1:0] voice_trigger;
    logic          steal_pulse;
    logic          busy;

    int checks = 0;
    int errors = 0;

    midi_voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_note_on    (evt_note_on),
        .evt_note       (evt_note),
        .evt_velocity   (evt_velocity),
        .panic          (panic),
        .voice_gate     (voice_gate),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_trigger  (voice_trigger),
        .steal_pulse    (steal_pulse),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        evt_valid = 1'b0;
        panic = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns #1 after the accepting edge (edge 0).
    task automatic accept_event(input logic on, input logic [6:0] n, input logic [6:0] v);
        int waitc = 0;
        @(negedge clk);
        while (!evt_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!evt_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: evt_ready=%b required 1", evt_ready);
        end
        evt_valid = 1'b1; evt_note_on = on; evt_note = n; evt_velocity = v;
        @(posedge clk); #1;
        evt_valid = 1'b0;
    endtask

    // From #1 after edge 0 to #1 after edge NV+1.
    task automatic wait_commit();
        repeat (NV + 1) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
        accept_event(on, n, v);
        wait_commit();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (voice_gate !== '0)  begin errors++; $display("FAIL reset_gate: got %b required 0", voice_gate); end
        checks++; if (voice_note !== '0)  begin errors++; $display("FAIL reset_note: got %h required 0", voice_note); end
        checks++; if (voice_trigger !== '0 || steal_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses: trig=%b steal=%b required 0", voice_trigger, steal_pulse); end
        checks++; if (evt_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_handshake: ready=%b busy=%b required 1/0", evt_ready, busy); end
        do_reset();
    endtask

    task automatic test_first_note();
        do_reset();
        accept_event(1'b1, 7'd60, 7'd100);
        repeat (NV) @(posedge clk);
        #1;
        checks++; if (voice_gate !== 4'b0000 || voice_trigger !== 4'b0000) begin errors++; $display("FAIL first_early: gate=%b trig=%b required 0000/0000", voice_gate, voice_trigger); end
        checks++; if (busy !== 1'b1 || evt_ready !== 1'b0) begin errors++; $display("FAIL first_busy: busy=%b ready=%b required 1/0", busy, evt_ready); end
        @(posedge clk); #1;
        checks++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL first_gate: got %b required 0001", voice_gate); end
        checks++; if (voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100) begin errors++; $display("FAIL first_data: note=%0d vel=%0d required 60/100", voice_note[6:0], voice_velocity[6:0]); end
        checks++; if (voice_trigger !== 4'b0001 || steal_pulse !== 1'b0) begin errors++; $display("FAIL first_trig: trig=%b steal=%b required 0001/0", voice_trigger, steal_pulse); end
        @(posedge clk); #1;
        checks++; if (voice_trigger !== 4'b0000 || evt_ready !== 1'b1) begin errors++; $display("FAIL first_after: trig=%b ready=%b required 0000/1", voice_trigger, evt_ready); end
    endtask

    task automatic test_steal();
        do_reset();
        send(1'b1, 7'd60, 7'd10);
        send(1'b1, 7'd62, 7'd20);
        send(1'b1, 7'd64, 7'd30);
        send(1'b1, 7'd65, 7'd40);
        checks++; if (voice_gate !== 4'b1111 || steal_pulse !== 1'b0) begin errors++; $display("FAIL steal_fill: gate=%b steal=%b required 1111/0", voice_gate, steal_pulse); end
        send(1'b1, 7'd67, 7'd90);
        checks++; if (voice_note !== {7'd65, 7'd64, 7'd62, 7'd67}) begin errors++; $display("FAIL steal_notes: got %h required %h", voice_note, {7'd65, 7'd64, 7'd62, 7'd67}); end
        checks++; if (voice_velocity !== {7'd40, 7'd30, 7'd20, 7'd90}) begin errors++; $display("FAIL steal_vels: got %h required %h", voice_velocity, {7'd40, 7'd30, 7'd20, 7'd90}); end
        checks++; if (steal_pulse !== 1'b1 || voice_trigger !== 4'b0001) begin errors++; $display("FAIL steal_pulse: steal=%b trig=%b required 1/0001", steal_pulse, voice_trigger); end
        @(posedge clk); #1;
        checks++; if (steal_pulse !== 1'b0) begin errors++; $display("FAIL steal_once: got %b required 0", steal_pulse); end
    endtask

    task automatic test_note_off();
        logic [NV*7-1:0] snap_note;
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd60, 7'd0);
        checks++; if (voice_gate !== 4'b0000 || voice_note[6:0] !== 7'd60) begin errors++; $display("FAIL off_release: gate=%b note=%0d required 0000/60", voice_gate, voice_note[6:0]); end
        checks++; if (voice_trigger !== 4'b0000 || voice_velocity[6:0] !== 7'd100) begin errors++; $display("FAIL off_retain: trig=%b vel=%0d required 0000/100", voice_trigger, voice_velocity[6:0]); end
        snap_note = voice_note;
        send(1'b0, 7'd61, 7'd64);
        checks++; if (voice_gate !== 4'b0000 || voice_note !== snap_note || voice_trigger !== 4'b0000) begin errors++; $display("FAIL off_nomatch: gate=%b note=%h trig=%b required 0000/%h/0000", voice_gate, voice_note, voice_trigger, snap_note); end
    endtask

    task automatic test_retrigger();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd60, 7'd50);
        checks++; if (voice_gate !== 4'b0001 || voice_trigger !== 4'b0001) begin errors++; $display("FAIL retrig_slot: gate=%b trig=%b required 0001/0001", voice_gate, voice_trigger); end
        checks++; if (voice_velocity[6:0] !== 7'd50 || voice_note[13:7] !== 7'd0) begin errors++; $display("FAIL retrig_data: vel0=%0d note1=%0d required 50/0", voice_velocity[6:0], voice_note[13:7]); end
    endtask

    task automatic test_panic();
        logic trig_seen;
        do_reset();
        send(1'b1, 7'd60, 7'd10);
        send(1'b1, 7'd62, 7'd20);
        send(1'b1, 7'd64, 7'd30);
        accept_event(1'b1, 7'd65, 7'd40);
        @(posedge clk); #1;
        panic = 1'b1;
        @(posedge clk); #1;
        checks++; if (voice_gate !== 4'b0000) begin errors++; $display("FAIL panic_gates: got %b required 0000", voice_gate); end
        checks++; if (evt_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL panic_ready: ready=%b busy=%b required 0/0", evt_ready, busy); end
        panic = 1'b0;
        @(posedge clk); #1;
        checks++; if (evt_ready !== 1'b1) begin errors++; $display("FAIL panic_release: ready=%b required 1", evt_ready); end
        trig_seen = 1'b0;
        for (int i = 0; i < NV + 2; i++) begin
            @(posedge clk); #1;
            trig_seen = trig_seen | (|voice_trigger) | steal_pulse;
        end
        checks++; if (trig_seen !== 1'b0 || voice_gate !== 4'b0000 || voice_note[27:21] !== 7'd0) begin errors++; $display("FAIL panic_discard: trig=%b gate=%b note3=%0d required 0/0000/0", trig_seen, voice_gate, voice_note[27:21]); end
        checks++; if (voice_note[20:0] !== {7'd64, 7'd62, 7'd60}) begin errors++; $display("FAIL panic_retain: got %h required %h", voice_note[20:0], {7'd64, 7'd62, 7'd60}); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] notes [6];
        int acc [$];
        int cyc = 0;
        int idx = 0;
        notes = '{7'd60, 7'd62, 7'd64, 7'd65, 7'd67, 7'd69};
        do_reset();
        evt_valid = 1'b1; evt_note_on = 1'b1; evt_velocity = 7'd80; evt_note = notes[0];
        while (idx < 6 && cyc < 200) begin
            @(negedge clk);
            if (evt_ready) begin
                acc.push_back(cyc);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 6) evt_note = notes[idx];
            cyc++;
        end
        evt_valid = 1'b0;
        checks++; if (acc.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d accepts required 6", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++; if (acc[i] - acc[i-1] != NV + 2) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d", i, acc[i] - acc[i-1], NV + 2); end
        end
        wait_commit();
        checks++; if (voice_gate !== 4'b1111 || voice_note !== {7'd65, 7'd64, 7'd69, 7'd67}) begin errors++; $display("FAIL b2b_final: gate=%b note=%h required 1111/%h", voice_gate, voice_note, {7'd65, 7'd64, 7'd69, 7'd67}); end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_steal();
        test_note_off();
        test_retrigger();
        test_panic();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
